// File: rtl/wb_grf_if.sv
// -----------------------------------------------------------------------------
// wb_grf_if
// Bundles the write-back / register-file signals of the single-cycle MIPS
// datapath so that the register file and its driver share one port.
//
// Signals
//   PC        32     PC of the instruction in write-back (PC+8 source, logging)
//   regw      1      register write enable from control
//   wbsel     2      write-back source: 0 alu_res, 1 mem_rdata, 2 PC+8, 3 reserved
//   wa        5      destination register number
//   alu_res   32     ALU result
//   mem_rdata 32     data-memory read data
//   ra1, ra2  5      read addresses
//   rd1, rd2  32     read data (combinational)
//   wcount    CNT_W  number of committed register writes
//
// Modports
//   master : the datapath side (drives the write/read requests)
//   slave  : the register file (wb_grf)
// -----------------------------------------------------------------------------
interface wb_grf_if #(
   parameter int CNT_W = 32
);
   logic [31:0]      PC;
   logic             regw;
   logic [1:0]       wbsel;
   logic [4:0]       wa;
   logic [31:0]      alu_res;
   logic [31:0]      mem_rdata;
   logic [4:0]       ra1;
   logic [4:0]       ra2;
   logic [31:0]      rd1;
   logic [31:0]      rd2;
   logic [CNT_W-1:0] wcount;

   modport master (
      output PC,
      output regw,
      output wbsel,
      output wa,
      output alu_res,
      output mem_rdata,
      output ra1,
      output ra2,
      input  rd1,
      input  rd2,
      input  wcount
   );

   modport slave (
      input  PC,
      input  regw,
      input  wbsel,
      input  wa,
      input  alu_res,
      input  mem_rdata,
      input  ra1,
      input  ra2,
      output rd1,
      output rd2,
      output wcount
   );
endinterface

// File: rtl/wb_grf.sv
// -----------------------------------------------------------------------------
// wb_grf
// Write-back stage plus 32 x 32-bit general register file of the single-cycle
// MIPS datapath. Selects the write-back value (ALU result, data-memory read
// data or PC+8), commits it to the destination register on the rising clock
// edge, serves two combinational read ports and counts committed writes.
// Every committed write is logged in the course reference-simulator format.
//
// Ports
//   clk  1      system clock, all state changes on posedge
//   clr  1      synchronous active-high reset
//   bus  slave modport of wb_grf_if (see rtl/wb_grf_if.sv)
//
// Parameters
//   CNT_W           width of the committed-write counter
//   LOG_EN_DEFAULT  1 enables the simulation write log, 0 silences it
//
// Configuration
//   WB_BYPASS_EN    when defined, a write in the current cycle is forwarded
//                   to rd1/rd2 whose read address matches the destination
//                   (write-first). When undefined no bypass mux exists and
//                   read-after-write hazards belong to the external
//                   forwarding unit.
// -----------------------------------------------------------------------------
module wb_grf #(
   parameter int CNT_W          = 32,
   parameter int LOG_EN_DEFAULT = 1
) (
   input logic   clk,
   input logic   clr,
   wb_grf_if.slave bus
);

   localparam logic [1:0] SEL_ALU = 2'd0;
   localparam logic [1:0] SEL_MEM = 2'd1;
   localparam logic [1:0] SEL_PC8 = 2'd2;
   localparam logic [1:0] SEL_RSV = 2'd3;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Register storage; entry 0 is never written so it stays at zero.
   logic [31:0]      regs_r [0:31];
   logic [CNT_W-1:0] wcount_r;

   logic [31:0] wd_s;
   logic        we_s;
   logic [31:0] stored1_s;
   logic [31:0] stored2_s;
   logic [31:0] rd1_s;
   logic [31:0] rd2_s;

   // Write-back source select; the reserved code yields zero but never commits.
   always_comb begin
      wd_s = 32'd0;
      case (bus.wbsel)
         SEL_ALU: wd_s = bus.alu_res;
         SEL_MEM: wd_s = bus.mem_rdata;
         SEL_PC8: wd_s = bus.PC + 32'd8;
         default: wd_s = 32'd0;
      endcase
   end

   // A write commits only for a real source and a non-zero destination.
   always_comb begin
      we_s = 1'b0;
      if (bus.regw && (bus.wbsel != SEL_RSV) && (bus.wa != 5'd0)) begin
         we_s = 1'b1;
      end else begin
         we_s = 1'b0;
      end
   end

   // Register file and write counter; clr drops any write in the same cycle.
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 32; i++) begin
            regs_r[i] <= 32'd0;
         end
         wcount_r <= {CNT_W{1'b0}};
      end else begin
         if (we_s) begin
            regs_r[bus.wa] <= wd_s;
            wcount_r       <= wcount_r + CNT_ONE;
         end
      end
   end

   // Stored-content read; register 0 is forced to zero independent of storage.
   always_comb begin
      stored1_s = 32'd0;
      stored2_s = 32'd0;
      if (bus.ra1 == 5'd0) begin
         stored1_s = 32'd0;
      end else begin
         stored1_s = regs_r[bus.ra1];
      end
      if (bus.ra2 == 5'd0) begin
         stored2_s = 32'd0;
      end else begin
         stored2_s = regs_r[bus.ra2];
      end
   end

`ifdef WB_BYPASS_EN
   // Write-first forwarding of the value being committed this cycle.
   always_comb begin
      rd1_s = stored1_s;
      rd2_s = stored2_s;
      if (we_s && !clr && (bus.ra1 == bus.wa)) begin
         rd1_s = wd_s;
      end else begin
         rd1_s = stored1_s;
      end
      if (we_s && !clr && (bus.ra2 == bus.wa)) begin
         rd2_s = wd_s;
      end else begin
         rd2_s = stored2_s;
      end
   end
`else
   // Reads show pre-edge register contents only.
   always_comb begin
      rd1_s = stored1_s;
      rd2_s = stored2_s;
   end
`endif

   assign bus.rd1    = rd1_s;
   assign bus.rd2    = rd2_s;
   assign bus.wcount = wcount_r;

`ifndef SYNTHESIS
   // Simulation write log in the reference-simulator format.
   always_ff @(posedge clk) begin
      if (!clr && we_s && (LOG_EN_DEFAULT != 0)) begin
         $display("@%h: $%d <= %h", bus.PC, bus.wa, wd_s);
      end
   end
`endif

endmodule

// File: tb/tb_wb_grf.sv
// -----------------------------------------------------------------------------
// tb_wb_grf
// Directed self-checking bench for wb_grf. The counter is built 4 bits wide
// so that its wrap can be reached with a handful of writes.
// -----------------------------------------------------------------------------
module tb_wb_grf;

   logic clk;
   logic clr;
   int   checks;
   int   errors;

   wb_grf_if #(.CNT_W(4)) bus ();

   wb_grf #(.CNT_W(4), .LOG_EN_DEFAULT(1)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // advance one rising edge and settle 1 time unit past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.regw  = 1'b0;
      bus.wbsel = 2'd0;
      bus.wa    = 5'd0;
   endtask

   task automatic wr(input logic [1:0] sel, input logic [4:0] a,
                     input logic [31:0] alu, input logic [31:0] mem,
                     input logic [31:0] pc);
      bus.regw      = 1'b1;
      bus.wbsel     = sel;
      bus.wa        = a;
      bus.alu_res   = alu;
      bus.mem_rdata = mem;
      bus.PC        = pc;
   endtask

   task automatic test_reset();
      clr = 1'b1;
      wr(2'd0, 5'd5, 32'h1234, 32'd0, 32'd0);
      bus.ra1 = 5'd5;
      bus.ra2 = 5'd5;
      tick();
      tick();
      clr = 1'b0;
      idle();
      #1;
      checks++;
      if (bus.rd1 !== 32'd0) begin
         errors++; $display("FAIL reset_rd1 got %h want %h", bus.rd1, 32'd0);
      end
      checks++;
      if (bus.rd2 !== 32'd0) begin
         errors++; $display("FAIL reset_rd2 got %h want %h", bus.rd2, 32'd0);
      end
      checks++;
      if (bus.wcount !== 4'd0) begin
         errors++; $display("FAIL reset_wcount got %0d want 0", bus.wcount);
      end
   endtask

   task automatic test_alu_write();
      logic [31:0] exp_pre;
      wr(2'd0, 5'd8, 32'hDEAD_BEEF, 32'd0, 32'h3000);
      bus.ra1 = 5'd8;
      #1;
      exp_pre = BYP ? 32'hDEAD_BEEF : 32'd0;
      checks++;
      if (bus.rd1 !== exp_pre) begin
         errors++; $display("FAIL alu_pre_edge got %h want %h", bus.rd1, exp_pre);
      end
      tick();
      idle();
      #1;
      checks++;
      if (bus.rd1 !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL alu_write got %h want deadbeef", bus.rd1);
      end
      checks++;
      if (bus.wcount !== 4'd1) begin
         errors++; $display("FAIL alu_wcount got %0d want 1", bus.wcount);
      end
   endtask

   task automatic test_load_link();
      wr(2'd1, 5'd9, 32'h0BAD, 32'h20, 32'h3000);
      tick();
      wr(2'd2, 5'd31, 32'h0BAD, 32'h0BAD, 32'h3004);
      tick();
      idle();
      bus.ra1 = 5'd9;
      bus.ra2 = 5'd31;
      #1;
      checks++;
      if (bus.rd1 !== 32'h20) begin
         errors++; $display("FAIL load_reg9 got %h want 00000020", bus.rd1);
      end
      checks++;
      if (bus.rd2 !== 32'h300C) begin
         errors++; $display("FAIL link_reg31 got %h want 0000300c", bus.rd2);
      end
      checks++;
      if (bus.wcount !== 4'd3) begin
         errors++; $display("FAIL load_link_wcount got %0d want 3", bus.wcount);
      end
      // PC+8 wraps modulo 2^32
      wr(2'd2, 5'd7, 32'h0BAD, 32'h0BAD, 32'hFFFF_FFFC);
      tick();
      idle();
      bus.ra1 = 5'd7;
      #1;
      checks++;
      if (bus.rd1 !== 32'h4) begin
         errors++; $display("FAIL pc8_wrap got %h want 00000004", bus.rd1);
      end
      checks++;
      if (bus.wcount !== 4'd4) begin
         errors++; $display("FAIL pc8_wcount got %0d want 4", bus.wcount);
      end
   endtask

   task automatic test_zero_reserved();
      wr(2'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'h3010);
      bus.ra1 = 5'd0;
      tick();
      idle();
      #1;
      checks++;
      if (bus.rd1 !== 32'd0) begin
         errors++; $display("FAIL reg0_read got %h want 0", bus.rd1);
      end
      checks++;
      if (bus.wcount !== 4'd4) begin
         errors++; $display("FAIL reg0_wcount got %0d want 4", bus.wcount);
      end
      wr(2'd3, 5'd4, 32'h77, 32'h77, 32'h3014);
      tick();
      wr(2'd3, 5'd8, 32'h1, 32'h1, 32'h3018);
      tick();
      idle();
      bus.ra1 = 5'd4;
      bus.ra2 = 5'd8;
      #1;
      checks++;
      if (bus.rd1 !== 32'd0) begin
         errors++; $display("FAIL rsv_reg4 got %h want 0", bus.rd1);
      end
      checks++;
      if (bus.rd2 !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL rsv_reg8 got %h want deadbeef", bus.rd2);
      end
      checks++;
      if (bus.wcount !== 4'd4) begin
         errors++; $display("FAIL rsv_wcount got %0d want 4", bus.wcount);
      end
   endtask

   task automatic test_bypass();
      logic [31:0] exp_pre;
      wr(2'd0, 5'd10, 32'h55, 32'd0, 32'h3020);
      bus.ra1 = 5'd10;
      bus.ra2 = 5'd10;
      #1;
      exp_pre = BYP ? 32'h55 : 32'd0;
      checks++;
      if (bus.rd1 !== exp_pre) begin
         errors++; $display("FAIL bypass_rd1 got %h want %h", bus.rd1, exp_pre);
      end
      checks++;
      if (bus.rd2 !== exp_pre) begin
         errors++; $display("FAIL bypass_rd2 got %h want %h", bus.rd2, exp_pre);
      end
      tick();
      idle();
      #1;
      checks++;
      if (bus.rd1 !== 32'h55) begin
         errors++; $display("FAIL bypass_commit got %h want 00000055", bus.rd1);
      end
      checks++;
      if (bus.wcount !== 4'd5) begin
         errors++; $display("FAIL bypass_wcount got %0d want 5", bus.wcount);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_mid;
      bus.ra1 = 5'd14;
      wr(2'd0, 5'd14, 32'h1, 32'd0, 32'h3030);
      tick();
      wr(2'd0, 5'd14, 32'h2, 32'd0, 32'h3034);
      #1;
      exp_mid = BYP ? 32'h2 : 32'h1;
      checks++;
      if (bus.rd1 !== exp_mid) begin
         errors++; $display("FAIL b2b_mid got %h want %h", bus.rd1, exp_mid);
      end
      tick();
      idle();
      #1;
      checks++;
      if (bus.rd1 !== 32'h2) begin
         errors++; $display("FAIL b2b_final got %h want 00000002", bus.rd1);
      end
      checks++;
      if (bus.wcount !== 4'd7) begin
         errors++; $display("FAIL b2b_wcount got %0d want 7", bus.wcount);
      end
   endtask

   task automatic test_mid_reset();
      wr(2'd0, 5'd11, 32'hAA, 32'd0, 32'h3040);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      wr(2'd0, 5'd12, 32'hBB, 32'd0, 32'h3044);
      bus.ra1 = 5'd11;
      bus.ra2 = 5'd8;
      #1;
      checks++;
      if (bus.rd1 !== 32'd0) begin
         errors++; $display("FAIL midrst_reg11 got %h want 0", bus.rd1);
      end
      checks++;
      if (bus.rd2 !== 32'd0) begin
         errors++; $display("FAIL midrst_reg8 got %h want 0", bus.rd2);
      end
      checks++;
      if (bus.wcount !== 4'd0) begin
         errors++; $display("FAIL midrst_wcount got %0d want 0", bus.wcount);
      end
      tick();
      idle();
      bus.ra1 = 5'd12;
      #1;
      checks++;
      if (bus.rd1 !== 32'hBB) begin
         errors++; $display("FAIL post_rst_write got %h want 000000bb", bus.rd1);
      end
      checks++;
      if (bus.wcount !== 4'd1) begin
         errors++; $display("FAIL post_rst_wcount got %0d want 1", bus.wcount);
      end
   endtask

   task automatic test_counter_wrap();
      // counter is at 1: 14 more writes bring it to 15
      for (int i = 0; i < 14; i++) begin
         wr(2'd0, 5'd13, 32'h100 + i, 32'd0, 32'h3100);
         tick();
      end
      idle();
      bus.ra1 = 5'd13;
      #1;
      checks++;
      if (bus.wcount !== 4'd15) begin
         errors++; $display("FAIL wrap_pre got %0d want 15", bus.wcount);
      end
      checks++;
      if (bus.rd1 !== 32'h10D) begin
         errors++; $display("FAIL wrap_last_data got %h want 0000010d", bus.rd1);
      end
      wr(2'd1, 5'd13, 32'd0, 32'hCAFE, 32'h3200);
      tick();
      idle();
      #1;
      checks++;
      if (bus.wcount !== 4'd0) begin
         errors++; $display("FAIL wrap_zero got %0d want 0", bus.wcount);
      end
      checks++;
      if (bus.rd1 !== 32'hCAFE) begin
         errors++; $display("FAIL wrap_data got %h want 0000cafe", bus.rd1);
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      clr           = 1'b1;
      bus.PC        = 32'd0;
      bus.regw      = 1'b0;
      bus.wbsel     = 2'd0;
      bus.wa        = 5'd0;
      bus.alu_res   = 32'd0;
      bus.mem_rdata = 32'd0;
      bus.ra1       = 5'd0;
      bus.ra2       = 5'd0;
      test_reset();
      test_alu_write();
      test_load_link();
      test_zero_reserved();
      test_bypass();
      test_back_to_back();
      test_mid_reset();
      test_counter_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_grf.md
Name: wb_grf

Overview:
- Write-back stage plus general register file for the single-cycle MIPS datapath. Sits directly downstream of the data memory and consumes its rdata.
- Selects the write-back value from the ALU result, the DM read data or PC+8, and commits it to one of 32 32-bit registers on the clock edge.
- Provides two combinational read ports to the decode/ALU path.
- Logs every committed write for comparison against the course reference simulator, and counts committed writes.

Parameters:
- CNT_W, 32, width of the committed-write counter.
- LOG_EN_DEFAULT, 1, runtime default of the write-log enable; 0 silences $display.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- clr  input  1  reset; synchronous, active-high.
- PC  input  32  PC of the instruction in write-back; used for PC+8 and logging.
- regw  input  1  register write enable from control.
- wbsel  input  2  write-back source: 0 = alu_res, 1 = mem_rdata, 2 = PC+8, 3 = reserved.
- wa  input  5  destination register number.
- alu_res  input  32  ALU result.
- mem_rdata  input  32  DM read data (DM rdata).
- ra1  input  5  read address, port 1.
- ra2  input  5  read address, port 2.
- rd1  output  32  read data, port 1.
- rd2  output  32  read data, port 2.
- wcount  output  CNT_W  number of committed register writes.

Behaviour:
- Single clock clk; reset clr is synchronous and active-high. There is no asynchronous path.
- Posedge with clr=1:
  - all 32 registers <= 0 and wcount <= 0;
  - any write requested in that cycle is dropped and not logged.
- Write data (combinational):
  - wd = alu_res when wbsel=0, mem_rdata when wbsel=1, PC+32'd8 when wbsel=2 (modulo 2^32; PC=32'hFFFF_FFFC gives 32'h0000_0004).
  - wbsel=3 suppresses the write entirely, even with regw=1.
- Commit: at posedge with clr=0, regw=1, wbsel!=3 and wa!=0:
  - reg[wa] <= wd;
  - wcount <= wcount+1, wrapping from all-ones to 0;
  - if logging is enabled, $display("@%h: $%d <= %h", PC, wa, wd) is issued in the same timestep.
- Register 0: reads always return 0. A write to wa=0 changes nothing, is not counted and is not logged.
- Reads: rd1 = reg[ra1] and rd2 = reg[ra2], combinational and zero latency. They show the pre-edge value unless WB_BYPASS_EN is defined.
- Latency: a written value becomes visible on rd1/rd2 the cycle after the commit edge.
- Reset values: rd1 = rd2 = 0 for any address after reset; wcount = 0.
- Reset mid-stream: clr wins over regw in the same cycle. The first write after clr deasserts commits normally at the next edge.
- Inputs with X on regw while clr=0 are a bench error. The RTL does not need to handle them.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: internal write-first forwarding.
  - If regw=1, wbsel!=3, wa!=0, clr=0 and ra1==wa, then rd1 = wd in the same cycle. rd2 follows the same rule with ra2.
- Undefined: rd1/rd2 always reflect stored register contents. The hazard must be resolved by the external forwarding unit.
- With the macro undefined, no bypass mux is instantiated.

Test Plan:
- Reset: clr=1 for 2 cycles with regw=1, wa=5, alu_res=32'h1234 -> after release, rd1(ra1=5)=0, wcount=0, no log line.
- ALU write: PC=32'h3000, regw=1, wbsel=0, wa=8, alu_res=32'hDEAD_BEEF -> next cycle rd1(ra1=8)=32'hDEAD_BEEF, wcount=1, log "@00003000: $ 8 <= deadbeef".
- Load and link:
  - wbsel=1, wa=9, mem_rdata=32'h20 -> reg9=32'h20.
  - wbsel=2, wa=31, PC=32'h3004 -> reg31=32'h300C.
  - wcount increments by 2.
- Register zero and reserved select:
  - wa=0, alu_res=32'hFFFF_FFFF -> rd1(ra1=0)=0, wcount unchanged.
  - wbsel=3, wa=4 -> reg4 unchanged, no log.
- Bypass: ra1=wa=10, alu_res=32'h55 in the same cycle -> rd1=32'h55 before the edge with WB_BYPASS_EN; old value (0) without it.
- Counter wrap: preload wcount with CNT_W=4 and 15 writes, then 1 more write -> wcount=0.
